alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Parametrised successor to the ALU operand-B select: resolves both ALU operands (A and B) from the register file, immediate, PC or constants.
- Applies priority forwarding from NUM_FWD later pipeline stages.
- Registers the result in a valid/ready pipeline slot between ID and EX.
- Detects load-use hazards and back-pressures ID until forwarded data is available.

Parameters:
- XLEN, 64, datapath width of operands and forwarding data.
- NUM_FWD, 3, number of forwarding sources; index 0 is the youngest stage (EX) and has highest priority.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  decoded immediate.
- read_data_1  in  XLEN  register-file rs1 value.
- read_data_2  in  XLEN  register-file rs2 value.
- rs1_idx  in  REG_IDX_W  rs1 index.
- rs2_idx  in  REG_IDX_W  rs2 index.
- alu_asel  in  2  alu_asel_op_enum.
- alu_bsel  in  2  alu_bsel_op_enum.
- fwd_valid  in  NUM_FWD  forwarding source holds a register write.
- fwd_busy  in  NUM_FWD  the source's result is not yet available (e.g. a load in EX).
- fwd_rd  in  NUM_FWD*REG_IDX_W  destination index per source.
- fwd_data  in  NUM_FWD*XLEN  result per source.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  a, b are valid for EX.
- out_ready  in  1  EX accepts.
- a  out  XLEN  registered operand A.
- b  out  XLEN  registered operand B.

Behaviour:
- Forwarding:
  - For each of rs1 and rs2, the lowest index i with fwd_valid[i], fwd_rd[i]==rs and rs!=0 wins, and fwd_data[i] replaces the register-file value.
  - With no match, the register-file value is used.
  - rs==0 always yields 0, regardless of read_data or any forwarding source.
- Hazard:
  - hazard = the winning match for a used operand has fwd_busy set.
  - rs1 is used when alu_asel==ASEL_REG; rs2 is used when alu_bsel==BSEL_REG.
  - A busy source that is shadowed by a higher-priority (lower-index) non-busy match causes no hazard.
- Operand A select: ASEL0→0, ASEL_REG→rs1 value, ASEL_PC→pc, ASEL3→0.
- Operand B select: BSEL0→0, BSEL_REG→rs2 value, BSEL_IMM→imm, BSEL_CONST4→64'd4 (zero-extended to XLEN).
- in_ready = !hazard && (!out_valid || out_ready). Fully combinational; no dependence on in_valid.
- Capture:
  - When in_valid && in_ready, a and b are loaded on the next rising edge and out_valid is set to 1.
  - When out_valid && out_ready && !(in_valid && in_ready), out_valid is cleared.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Hold: while out_valid && !out_ready, a and b are stable even if forwarding inputs change. Operands are resolved only at capture.
- Flush has priority over capture: out_valid becomes 0 next cycle and the incoming instruction is dropped. a and b keep their values (don't-care).
- Reset:
  - Asynchronous assert: out_valid=0, a=0, b=0 immediately.
  - in_ready follows its equation and is 1 when not hazarded.
  - Reset mid-hold discards the held instruction.
- Simultaneous events: a drain and a fill in the same cycle keep out_valid=1 with the new operands.

Optional Feature:
- ALU_OPERAND_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt, 32 bits.
  - Increments by 1 on each cycle with in_valid && hazard.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 asynchronously; not cleared by flush.
- Undefined: the port and the counter do not exist. Behaviour is otherwise identical.

Decomposition:
- CorePack holds:
  - alu_asel_op_enum {ASEL0, ASEL_REG, ASEL_PC, ASEL3}.
  - alu_bsel_op_enum {BSEL0, BSEL_REG, BSEL_IMM, BSEL_CONST4}, with BSEL_CONST4 replacing BSEL3.
  - data_t.
- Sub-module fwd_resolve: purely combinational. Inputs are one rs index, the register-file value and the forwarding arrays. Outputs are the value and a busy flag. Instantiated twice (rs1, rs2).

Test Plan:
- No forwarding: rs1=3, read_data_1=0x11, asel=ASEL_REG, bsel=BSEL_IMM, imm=0x20, out_ready=1 → next cycle out_valid=1, a=0x11, b=0x20.
- Priority: fwd_valid=3'b011, fwd_rd[0]=fwd_rd[1]=5, fwd_data[0]=0xAA, fwd_data[1]=0xBB, rs2=5, bsel=BSEL_REG → b=0xAA. Repeat with rs2=0 → b=0.
- Load-use: fwd_busy[0]=1 matching rs1 with ASEL_REG → in_ready=0 and nothing captured for 2 cycles. Clear fwd_busy with fwd_data=0x77 → captured, a=0x77. With the counter macro, stall_cnt=2.
- Back-pressure: out_ready=0 with out_valid=1 → in_ready=0. Change fwd_data → a and b unchanged. Raise out_ready → drain and fill in the same cycle.
- Flush: flush=1 together with in_valid=1, in_ready=1 → out_valid=0 next cycle.
- Reset: assert rst mid-hold → out_valid, a and b become 0 without waiting for a clock edge.
- Constants: asel=ASEL_PC, pc=0x8000_0000, bsel=BSEL_CONST4 → a=0x8000_0000, b=4.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared operand-select encodings and data type for the ALU operand stage
package alu_operand_stage_pkg;

  localparam int CORE_XLEN = 64;

  typedef logic [CORE_XLEN-1:0] data_t;

  typedef enum logic [1:0] {
    ASEL0    = 2'd0,
    ASEL_REG = 2'd1,
    ASEL_PC  = 2'd2,
    ASEL3    = 2'd3
  } alu_asel_op_enum;

  // Encoding 3 was a spare zero select before; it now supplies the constant 4.
  typedef enum logic [1:0] {
    BSEL0       = 2'd0,
    BSEL_REG    = 2'd1,
    BSEL_IMM    = 2'd2,
    BSEL_CONST4 = 2'd3
  } alu_bsel_op_enum;

endpackage

// File: rtl/alu_operand_stage_fwd_resolve.sv
// rtl/alu_operand_stage_fwd_resolve.sv - priority forwarding resolve for one source register
module fwd_resolve #(
  parameter int XLEN      = 64,
  parameter int NUM_FWD   = 3,
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0]         rs_idx,
  input  logic [XLEN-1:0]              rf_data,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD-1:0]           fwd_busy,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
  output logic [XLEN-1:0]              value,
  output logic                         busy
);

  // Walk oldest to youngest so the lowest-index match is the last one written.
  always_comb begin
    value = rf_data;
    busy  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i*REG_IDX_W +: REG_IDX_W] == rs_idx)) begin
        value = fwd_data[i*XLEN +: XLEN];
        busy  = fwd_busy[i];
      end
    end
    if (rs_idx == '0) begin
      value = '0;
      busy  = 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand resolve, forwarding and hazard slot; ALU_OPERAND_STALL_CNT_EN adds stall_cnt
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NUM_FWD   = 3,
  parameter int REG_IDX_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              read_data_1,
  input  logic [XLEN-1:0]              read_data_2,
  input  logic [REG_IDX_W-1:0]         rs1_idx,
  input  logic [REG_IDX_W-1:0]         rs2_idx,
  input  logic [1:0]                   alu_asel,
  input  logic [1:0]                   alu_bsel,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD-1:0]           fwd_busy,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef ALU_OPERAND_STALL_CNT_EN
  output logic [31:0]                  stall_cnt,
`endif
  output logic [XLEN-1:0]              a,
  output logic [XLEN-1:0]              b
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  logic [XLEN-1:0] a_d, a_q;
  logic [XLEN-1:0] b_d, b_q;
  logic            out_valid_d, out_valid_q;

  fwd_resolve #(
    .XLEN      (XLEN),
    .NUM_FWD   (NUM_FWD),
    .REG_IDX_W (REG_IDX_W)
  ) u_rs1 (
    .rs_idx    (rs1_idx),
    .rf_data   (read_data_1),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (rs1_val),
    .busy      (rs1_busy)
  );

  fwd_resolve #(
    .XLEN      (XLEN),
    .NUM_FWD   (NUM_FWD),
    .REG_IDX_W (REG_IDX_W)
  ) u_rs2 (
    .rs_idx    (rs2_idx),
    .rf_data   (read_data_2),
    .fwd_valid (fwd_valid),
    .fwd_busy  (fwd_busy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (rs2_val),
    .busy      (rs2_busy)
  );

  // A busy source only stalls when the instruction actually reads that register.
  always_comb begin
    rs1_used = (alu_asel_op_enum'(alu_asel) == ASEL_REG);
    rs2_used = (alu_bsel_op_enum'(alu_bsel) == BSEL_REG);
    hazard   = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);
    in_ready = !hazard && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    op_a = '0;
    case (alu_asel_op_enum'(alu_asel))
      ASEL0:    op_a = '0;
      ASEL_REG: op_a = rs1_val;
      ASEL_PC:  op_a = pc;
      ASEL3:    op_a = '0;
      default:  op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    case (alu_bsel_op_enum'(alu_bsel))
      BSEL0:       op_b = '0;
      BSEL_REG:    op_b = rs2_val;
      BSEL_IMM:    op_b = imm;
      BSEL_CONST4: op_b = {{(XLEN-3){1'b0}}, 3'b100};
      default:     op_b = '0;
    endcase
  end

  // Flush wins over a same-cycle accept; operands are left as they are.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      a_d         = op_a;
      b_d         = op_b;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;

`ifdef ALU_OPERAND_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized and directed check of alu_operand_stage against a behavioural model
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  data_t        pc, imm, read_data_1, read_data_2;
  logic [4:0]   rs1_idx, rs2_idx;
  logic [1:0]   alu_asel, alu_bsel;
  logic [2:0]   fwd_valid, fwd_busy;
  logic [14:0]  fwd_rd;
  logic [191:0] fwd_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  data_t        a, b;
`ifdef ALU_OPERAND_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic        m_valid;
  data_t       m_a, m_b;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc          (pc),
    .imm         (imm),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .alu_asel    (alu_asel),
    .alu_bsel    (alu_bsel),
    .fwd_valid   (fwd_valid),
    .fwd_busy    (fwd_busy),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef ALU_OPERAND_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .a           (a),
    .b           (b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // First matching source scanning from the youngest stage; x0 reads as zero.
  function automatic void resolve(input logic [4:0] rs, input data_t rf,
                                  output data_t val, output logic busy);
    val  = rf;
    busy = 1'b0;
    if (rs == 5'd0) begin
      val = '0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == rs) begin
        val  = fwd_data[i*64 +: 64];
        busy = fwd_busy[i];
        return;
      end
    end
  endfunction

  function automatic logic model_hazard();
    data_t v;
    logic  b1, b2;
    resolve(rs1_idx, read_data_1, v, b1);
    resolve(rs2_idx, read_data_2, v, b2);
    return (alu_asel == 2'd1 && b1) || (alu_bsel == 2'd1 && b2);
  endfunction

  function automatic logic model_ready();
    return !model_hazard() && (!m_valid || out_ready);
  endfunction

  function automatic data_t model_a();
    data_t v;
    logic  bz;
    resolve(rs1_idx, read_data_1, v, bz);
    case (alu_asel)
      2'd1:    return v;
      2'd2:    return pc;
      default: return '0;
    endcase
  endfunction

  function automatic data_t model_b();
    data_t v;
    logic  bz;
    resolve(rs2_idx, read_data_2, v, bz);
    case (alu_bsel)
      2'd1:    return v;
      2'd2:    return imm;
      2'd3:    return 64'd4;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_stall = '0;
    end else begin
      if (in_valid && model_hazard() && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && model_ready()) begin
        m_valid = 1'b1;
        m_a     = model_a();
        m_b     = model_b();
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        check("a", a, m_a);
        check("b", b, m_b);
      end
`ifdef ALU_OPERAND_STALL_CNT_EN
      check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; pc = '0; imm = '0; read_data_1 = '0; read_data_2 = '0;
    rs1_idx = '0; rs2_idx = '0; alu_asel = '0; alu_bsel = '0;
    fwd_valid = '0; fwd_busy = '0; fwd_rd = '0; fwd_data = '0;
    flush = 0; out_ready = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset a", a, 64'd0);
    check("reset b", b, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Plain register/immediate operands.
    in_valid = 1; rs1_idx = 5'd3; read_data_1 = 64'h11; alu_asel = 2'd1;
    alu_bsel = 2'd2; imm = 64'h20;
    step();
    check("nofwd out_valid", {63'd0, out_valid}, 64'd1);
    check("nofwd a", a, 64'h11);
    check("nofwd b", b, 64'h20);

    // Youngest matching source wins; x0 ignores forwarding.
    fwd_valid = 3'b011; fwd_rd[0 +: 5] = 5'd5; fwd_rd[5 +: 5] = 5'd5;
    fwd_data[0 +: 64] = 64'hAA; fwd_data[64 +: 64] = 64'hBB;
    rs2_idx = 5'd5; read_data_2 = 64'hCC; alu_bsel = 2'd1; alu_asel = 2'd0;
    step();
    check("prio b", b, 64'hAA);
    rs2_idx = 5'd0;
    step();
    check("x0 b", b, 64'h0);

    // Load-use stall for two cycles, then release with forwarded data.
    fwd_valid = 3'b001; fwd_busy = 3'b001; fwd_rd = '0; fwd_rd[0 +: 5] = 5'd7;
    rs1_idx = 5'd7; alu_asel = 2'd1; alu_bsel = 2'd0;
    #1 check("loaduse in_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("loaduse stall1", {63'd0, out_valid}, 64'd0);
    step();
    check("loaduse stall2", {63'd0, out_valid}, 64'd0);
    fwd_busy = 3'b000; fwd_data[0 +: 64] = 64'h77;
    #1 check("loaduse release", {63'd0, in_ready}, 64'd1);
    step();
    check("loaduse a", a, 64'h77);
`ifdef ALU_OPERAND_STALL_CNT_EN
    check("loaduse stall_cnt", {32'd0, stall_cnt}, 64'd2);
`endif

    // Back-pressure hold, then drain+fill with PC / constant-4 operands.
    out_ready = 0; alu_asel = 2'd2; pc = 64'h8000_0000; alu_bsel = 2'd3;
    #1 check("bp in_ready", {63'd0, in_ready}, 64'd0);
    fwd_data[0 +: 64] = 64'h99;
    step();
    check("hold a", a, 64'h77);
    check("hold valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1;
    step();
    check("fill valid", {63'd0, out_valid}, 64'd1);
    check("const a", a, 64'h8000_0000);
    check("const b", b, 64'd4);

    flush = 1;
    step();
    check("flush valid", {63'd0, out_valid}, 64'd0);
    flush = 0;

    // Asynchronous reset while holding.
    out_ready = 0; alu_bsel = 2'd2; imm = 64'h1234;
    step();
    check("prehold valid", {63'd0, out_valid}, 64'd1);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("async out_valid", {63'd0, out_valid}, 64'd0);
    check("async a", a, 64'd0);
    check("async b", b, 64'd0);
    step();
    rst = 1'b0;
    idle();

    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      pc          = {$urandom, $urandom};
      imm         = {$urandom, $urandom};
      read_data_1 = {$urandom, $urandom};
      read_data_2 = {$urandom, $urandom};
      rs1_idx     = 5'($urandom_range(0, 3));
      rs2_idx     = 5'($urandom_range(0, 3));
      alu_asel    = 2'($urandom_range(0, 3));
      alu_bsel    = 2'($urandom_range(0, 3));
      fwd_valid   = 3'($urandom);
      fwd_busy    = 3'($urandom) & 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        fwd_rd[i*5 +: 5]    = 5'($urandom_range(0, 3));
        fwd_data[i*64 +: 64] = {$urandom, $urandom};
      end
      step();
    end

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
